// File: rtl/reg_cmd_sequencer_pkg.sv
// Shared FunSel codes and sequencer state encoding for the
// FunSel-register command sequencer.
package reg_cmd_sequencer_pkg;

  typedef enum logic [1:0] {
    FS_CLEAR = 2'b00,
    FS_LOAD  = 2'b01,
    FS_DEC   = 2'b10,
    FS_INC   = 2'b11
  } funsel_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ISSUE  = 2'b01,
    S_SETTLE = 2'b10,
    S_CHECK  = 2'b11
  } state_e;

  // Increment and decrement repeat; clear and load are single shots.
  function automatic logic is_step(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/reg_cmd_sequencer_if.sv
// Command handshake plus register-side stimulus/readback bundle.
// slave is the sequencer's view; master is the control-unit view.
interface reg_cmd_sequencer_if #(
  parameter int N  = 4,
  parameter int CW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [N-1:0]  cmd_data;
  logic [CW-1:0] cmd_count;
  logic [1:0]    reg_funsel;
  logic          reg_enable;
  logic [N-1:0]  reg_data_in;
  logic [N-1:0]  reg_q;
  logic          busy;
  logic          done;
  logic [N-1:0]  result;
  logic          mismatch;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    input  cmd_count, reg_q,
    output cmd_ready, reg_funsel,
    output reg_enable, reg_data_in,
    output busy, done, result, mismatch
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    output cmd_count, reg_q,
    input  cmd_ready, reg_funsel,
    input  reg_enable, reg_data_in,
    input  busy, done, result, mismatch
  );
endinterface

// File: rtl/reg_cmd_sequencer.sv
// Drives clear/load/inc/dec pulses into a FunSel register and
// checks the read-back value against an internal expected model.
module reg_cmd_sequencer
  import reg_cmd_sequencer_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic clk,
  input  logic reset,
  reg_cmd_sequencer_if.slave bus
);

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [N-1:0]  exp_q, exp_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  result_q, result_d;
  logic          mism_q, mism_d;
  logic          en_q, en_d;
  logic [1:0]    fs_q, fs_d;
  logic [N-1:0]  din_q, din_d;

  logic accept;
  logic step;
  logic zero_cnt;

  // ready is only ever high in IDLE or CHECK
  assign accept   = bus.cmd_valid && ready_q;
  assign step     = is_step(bus.cmd_op);
  assign zero_cnt = (bus.cmd_count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept)
          state_d = (step && zero_cnt) ? S_SETTLE
                                       : S_ISSUE;
      end
      S_ISSUE: begin
        if (rem_q == CW'(1)) state_d = S_SETTLE;
      end
      S_SETTLE: state_d = S_CHECK;
      S_CHECK: begin
        if (accept)
          state_d = (step && zero_cnt) ? S_SETTLE
                                       : S_ISSUE;
        else
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    rem_d    = rem_q;
    exp_d    = exp_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    mism_d   = mism_q;
    en_d     = en_q;
    fs_d     = fs_q;
    din_d    = din_q;

    unique case (state_q)
      S_ISSUE: begin
        rem_d = rem_q - CW'(1);
        unique case (1'b1)
          (op_q == FS_INC): exp_d = exp_q + N'(1);
          (op_q == FS_DEC): exp_d = exp_q - N'(1);
          default:          exp_d = exp_q;
        endcase
        if (rem_q == CW'(1)) en_d = 1'b0;
      end
      S_SETTLE: begin
        done_d   = 1'b1;
        result_d = bus.reg_q;
        mism_d   = (bus.reg_q != exp_q);
        ready_d  = 1'b1;
        busy_d   = 1'b0;
      end
      default: ;
    endcase

    // Accept from IDLE, or on the edge that closes the done cycle.
    if (accept) begin
      op_d    = bus.cmd_op;
      ready_d = 1'b0;
      busy_d  = 1'b1;
      rem_d   = step ? bus.cmd_count : CW'(1);
      unique case (bus.cmd_op)
        FS_CLEAR: exp_d = '0;
        FS_LOAD:  exp_d = bus.cmd_data;
        default:  exp_d = bus.reg_q;
      endcase
      if (!(step && zero_cnt)) begin
        en_d  = 1'b1;
        fs_d  = bus.cmd_op;
        din_d = (bus.cmd_op == FS_LOAD)
              ? bus.cmd_data : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= FS_CLEAR;
      rem_q    <= '0;
      exp_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      mism_q   <= 1'b0;
      en_q     <= 1'b0;
      fs_q     <= FS_CLEAR;
      din_q    <= '0;
    end else begin
      op_q     <= op_d;
      rem_q    <= rem_d;
      exp_q    <= exp_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      mism_q   <= mism_d;
      en_q     <= en_d;
      fs_q     <= fs_d;
      din_q    <= din_d;
    end
  end

  assign bus.cmd_ready   = ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.mismatch    = mism_q;
  assign bus.reg_enable  = en_q;
  assign bus.reg_funsel  = fs_q;
  assign bus.reg_data_in = din_q;

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Bench: directed plan plus random ops against an arithmetic
// model of the FunSel register and the sequencer's timing rules.
module tb_reg_cmd_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_cmd_sequencer_if #(.N(4), .CW(4)) bus ();

  reg_cmd_sequencer #(.N(4), .CW(4)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Partner FunSel register; it has no reset of its own.
  logic [3:0] reg_val = 4'h0;
  logic       stuck   = 1'b0;
  always @(posedge clk)
    if (bus.reg_enable)
      case (bus.reg_funsel)
        2'b00: reg_val <= 4'h0;
        2'b01: reg_val <= bus.reg_data_in;
        2'b10: reg_val <= reg_val - 4'h1;
        default: reg_val <= reg_val + 4'h1;
      endcase
  assign bus.reg_q = stuck ? 4'h0 : reg_val;

  int n_cmp = 0;
  int n_err = 0;
  int model = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input int op, input int d,
                      input int k);
    int w;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'(op);
    bus.cmd_data  = 4'(d);
    bus.cmd_count = 4'(k);
    w = 0;
    while (!bus.cmd_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", 32'(w < 60), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_data  = 4'($urandom);
    bus.cmd_count = 4'($urandom);
  endtask

  // Follows one accepted op to its done cycle.
  task automatic track(input int op, input int d,
                       input int k, input string tag);
    int fin, lat_e, en_e, din_e, m, n_en, bad, rdy_bad;
    logic got;
    case (op)
      0: fin = 0;
      1: fin = d;
      2: fin = (model - k) & 15;
      default: fin = (model + k) & 15;
    endcase
    if (op >= 2) begin
      lat_e = (k == 0) ? 1 : k + 1;
      en_e  = k;
    end else begin
      lat_e = 2;
      en_e  = 1;
    end
    din_e = (op == 1) ? d : 0;
    got = 0; n_en = 0; bad = 0; rdy_bad = 0; m = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      m = i;
      if (bus.done) begin
        got = 1;
        break;
      end
      if (bus.cmd_ready || !bus.busy) rdy_bad++;
      if (bus.reg_enable) begin
        n_en++;
        if (bus.reg_funsel !== 2'(op)) bad++;
        if (bus.reg_data_in !== 4'(din_e)) bad++;
      end
    end
    check({tag, ".done"}, 32'(got), 1);
    check({tag, ".lat"}, m - 1, lat_e);
    check({tag, ".en_cycles"}, n_en, en_e);
    check({tag, ".pulse_bad"}, bad, 0);
    check({tag, ".busy_hs"}, rdy_bad, 0);
    check({tag, ".result"}, 32'(bus.result),
          stuck ? 0 : fin);
    check({tag, ".mismatch"}, 32'(bus.mismatch),
          stuck ? 32'(fin != 0) : 0);
    check({tag, ".ready"}, 32'(bus.cmd_ready), 1);
    check({tag, ".busy"}, 32'(bus.busy), 0);
    model = fin;
  endtask

  task automatic run(input int op, input int d,
                     input int k, input string tag);
    send(op, d, k);
    scramble();
    track(op, d, k, tag);
  endtask

  initial begin
    int op, d, k;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 4'h0;
    bus.cmd_count = 4'h0;
    #12;
    check("rst.ready", 32'(bus.cmd_ready), 1);
    check("rst.busy", 32'(bus.busy), 0);
    check("rst.done", 32'(bus.done), 0);
    check("rst.mism", 32'(bus.mismatch), 0);
    check("rst.result", 32'(bus.result), 0);
    check("rst.en", 32'(bus.reg_enable), 0);
    check("rst.fs", 32'(bus.reg_funsel), 0);
    check("rst.din", 32'(bus.reg_data_in), 0);
    @(negedge clk);
    rst = 1'b0;

    run(1, 4'b0010, 0, "load2");
    run(3, 0, 3, "inc3");
    run(1, 4'b1110, 0, "loadE");
    run(3, 0, 3, "inc_wrap");
    run(2, 0, 2, "dec_wrap");
    run(1, 4'b0110, 0, "load6");
    run(0, 0, 0, "clear");
    run(3, 0, 0, "inc0");

    // A different op held on valid while busy must wait.
    send(3, 0, 4);
    bus.cmd_op    = 2'b10;
    bus.cmd_count = 4'd1;
    track(3, 0, 4, "inc4_held");
    @(posedge clk);
    #1;
    scramble();
    track(2, 0, 1, "held_dec");

    stuck = 1'b1;
    run(1, 4'b1010, 0, "stuck");
    stuck = 1'b0;
    model = 4'b1010;

    send(3, 0, 5);
    scramble();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort.en", 32'(bus.reg_enable), 0);
    check("abort.busy", 32'(bus.busy), 0);
    check("abort.done", 32'(bus.done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model = (model + 1) & 15;
    k = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done || bus.reg_enable) k++;
    end
    check("abort.quiet", k, 0);
    check("abort.ready", 32'(bus.cmd_ready), 1);
    check("abort.regq", 32'(bus.reg_q), model);
    run(1, 4'b0011, 0, "post_rst");

    for (int i = 0; i < 24; i++) begin
      op = int'($urandom_range(0, 3));
      d  = int'($urandom_range(0, 15));
      k  = int'($urandom_range(0, 15));
      run(op, d, k, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=hang expected=finish");
    $fatal(1, "timeout");
  end

endmodule
